// File: rtl/axi4lite_axi4_bridge.sv
// AXI4-Lite slave to single-beat AXI4 master bridge for the DDR3 controller port.
// Independent write and read FSMs, init-done gating, response timeout with
// late-response drain, and ID/RLAST checking on returned responses.
module axi4lite_axi4_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned TXN_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    axi_rst_i,
  input  logic                    init_done_i,
  // AXI4-Lite write slave
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  // AXI4-Lite read slave
  input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [DATA_WIDTH-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  // AXI4 write master
  output logic [ID_WIDTH-1:0]     m_axi_awid_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr_o,
  output logic [7:0]              m_axi_awlen_o,
  output logic [2:0]              m_axi_awsize_o,
  output logic [1:0]              m_axi_awburst_o,
  output logic                    m_axi_awlock_o,
  output logic [3:0]              m_axi_awcache_o,
  output logic [2:0]              m_axi_awprot_o,
  output logic [3:0]              m_axi_awqos_o,
  output logic                    m_axi_awvalid_o,
  input  logic                    m_axi_awready_i,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb_o,
  output logic                    m_axi_wlast_o,
  output logic                    m_axi_wvalid_o,
  input  logic                    m_axi_wready_i,
  input  logic [ID_WIDTH-1:0]     m_axi_bid_i,
  input  logic [1:0]              m_axi_bresp_i,
  input  logic                    m_axi_bvalid_i,
  output logic                    m_axi_bready_o,
  // AXI4 read master
  output logic [ID_WIDTH-1:0]     m_axi_arid_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
  output logic [7:0]              m_axi_arlen_o,
  output logic [2:0]              m_axi_arsize_o,
  output logic [1:0]              m_axi_arburst_o,
  output logic                    m_axi_arlock_o,
  output logic [3:0]              m_axi_arcache_o,
  output logic [2:0]              m_axi_arprot_o,
  output logic [3:0]              m_axi_arqos_o,
  output logic                    m_axi_arvalid_o,
  input  logic                    m_axi_arready_i,
  input  logic [ID_WIDTH-1:0]     m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
  input  logic [1:0]              m_axi_rresp_i,
  input  logic                    m_axi_rlast_i,
  input  logic                    m_axi_rvalid_i,
  output logic                    m_axi_rready_o,
  output logic                    timeout_o
);

  localparam int unsigned OFFS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0]       TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [ID_WIDTH-1:0] TXNID = ID_WIDTH'(TXN_ID);
  localparam logic                TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {WIdle, WIssue, WResp, WLresp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RIssue, RResp, RLresp} rd_state_e;

  // Bad ID or missing last beat is reported as SLVERR; EXOKAY collapses to OKAY.
  function automatic logic [1:0] map_resp(input logic [1:0] resp, input logic ok);
    if (!ok)         return 2'b10;
    else if (resp[1]) return resp;
    else             return 2'b00;
  endfunction

  wr_state_e                 wr_state_q, wr_state_d;
  logic                      aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]     aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [DATA_WIDTH/8-1:0]   w_strb_q, w_strb_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      wdrain_q, wdrain_d;
  logic [TW-1:0]             wr_timer_q, wr_timer_d;
  logic                      wr_timeout;

  rd_state_e                 rd_state_q, rd_state_d;
  logic                      ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0]     ar_addr_q, ar_addr_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rdrain_q, rdrain_d;
  logic [TW-1:0]             rd_timer_q, rd_timer_d;
  logic                      rd_timeout;
  logic                      timeout_q;

  // Static AXI4 fields: single aligned INCR beat.
  assign m_axi_awid_o    = TXNID;
  assign m_axi_awaddr_o  = {aw_addr_q[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
  assign m_axi_awlen_o   = 8'd0;
  assign m_axi_awsize_o  = 3'(OFFS);
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = 4'b0011;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_awqos_o   = 4'd0;
  assign m_axi_wdata_o   = w_data_q;
  assign m_axi_wstrb_o   = w_strb_q;
  assign m_axi_wlast_o   = 1'b1;
  assign m_axi_arid_o    = TXNID;
  assign m_axi_araddr_o  = {ar_addr_q[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
  assign m_axi_arlen_o   = 8'd0;
  assign m_axi_arsize_o  = 3'(OFFS);
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = 4'b0011;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arqos_o   = 4'd0;
  assign axi_bresp_o     = bresp_q;
  assign axi_rdata_o     = rdata_q;
  assign axi_rresp_o     = rresp_q;
  assign timeout_o       = timeout_q;

  // Write FSM next-state and channel handshakes.
  always_comb begin
    wr_state_d      = wr_state_q;
    aw_full_d       = aw_full_q;
    w_full_d        = w_full_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    aw_addr_d       = aw_addr_q;
    w_data_d        = w_data_q;
    w_strb_d        = w_strb_q;
    bresp_d         = bresp_q;
    wdrain_d        = wdrain_q;
    wr_timer_d      = wr_timer_q;
    wr_timeout      = 1'b0;
    axi_awready_o   = 1'b0;
    axi_wready_o    = 1'b0;
    axi_bvalid_o    = 1'b0;
    m_axi_awvalid_o = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    // A late B after a timeout is swallowed here regardless of state.
    m_axi_bready_o  = wdrain_q;
    if (wdrain_q && m_axi_bvalid_i) wdrain_d = 1'b0;
    unique case (wr_state_q)
      WIdle: begin
        axi_awready_o = axi_rst_i & init_done_i & ~aw_full_q;
        axi_wready_o  = axi_rst_i & init_done_i & ~w_full_q;
        if (axi_awready_o && axi_awvalid_i) begin
          aw_full_d = 1'b1;
          aw_addr_d = axi_awaddr_i;
        end
        if (axi_wready_o && axi_wvalid_i) begin
          w_full_d = 1'b1;
          w_data_d = axi_wdata_i;
          w_strb_d = axi_wstrb_i;
        end
        if (aw_full_d && w_full_d && !wdrain_q) begin
          wr_state_d = WIssue;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      WIssue: begin
        m_axi_awvalid_o = ~aw_done_q;
        m_axi_wvalid_o  = ~w_done_q;
        if (m_axi_awvalid_o && m_axi_awready_i) aw_done_d = 1'b1;
        if (m_axi_wvalid_o && m_axi_wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          wr_state_d = WResp;
          wr_timer_d = '0;
        end
      end
      WResp: begin
        m_axi_bready_o = 1'b1;
        if (wr_timer_q != TMAX) wr_timer_d = wr_timer_q + 1'b1;
        if (m_axi_bvalid_i) begin
          bresp_d    = map_resp(m_axi_bresp_i, m_axi_bid_i == TXNID);
          wr_state_d = WLresp;
        end else if (TO_EN && wr_timer_d == TMAX) begin
          bresp_d    = 2'b10;
          wdrain_d   = 1'b1;
          wr_timeout = 1'b1;
          wr_state_d = WLresp;
        end
      end
      WLresp: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) begin
          wr_state_d = WIdle;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  // Read FSM next-state and channel handshakes.
  always_comb begin
    rd_state_d      = rd_state_q;
    ar_full_d       = ar_full_q;
    ar_addr_d       = ar_addr_q;
    rdata_d         = rdata_q;
    rresp_d         = rresp_q;
    rdrain_d        = rdrain_q;
    rd_timer_d      = rd_timer_q;
    rd_timeout      = 1'b0;
    axi_arready_o   = 1'b0;
    axi_rvalid_o    = 1'b0;
    m_axi_arvalid_o = 1'b0;
    m_axi_rready_o  = rdrain_q;
    if (rdrain_q && m_axi_rvalid_i) rdrain_d = 1'b0;
    unique case (rd_state_q)
      RIdle: begin
        axi_arready_o = axi_rst_i & init_done_i & ~ar_full_q;
        if (axi_arready_o && axi_arvalid_i) begin
          ar_full_d = 1'b1;
          ar_addr_d = axi_araddr_i;
        end
        if (ar_full_d && !rdrain_q) rd_state_d = RIssue;
      end
      RIssue: begin
        m_axi_arvalid_o = 1'b1;
        if (m_axi_arready_i) begin
          rd_state_d = RResp;
          rd_timer_d = '0;
        end
      end
      RResp: begin
        m_axi_rready_o = 1'b1;
        if (rd_timer_q != TMAX) rd_timer_d = rd_timer_q + 1'b1;
        if (m_axi_rvalid_i) begin
          rdata_d    = m_axi_rdata_i;
          rresp_d    = map_resp(m_axi_rresp_i, (m_axi_rid_i == TXNID) && m_axi_rlast_i);
          rd_state_d = RLresp;
        end else if (TO_EN && rd_timer_d == TMAX) begin
          rdata_d    = '0;
          rresp_d    = 2'b10;
          rdrain_d   = 1'b1;
          rd_timeout = 1'b1;
          rd_state_d = RLresp;
        end
      end
      RLresp: begin
        axi_rvalid_o = 1'b1;
        if (axi_rready_i) begin
          rd_state_d = RIdle;
          ar_full_d  = 1'b0;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge axi_rst_i) begin
    if (!axi_rst_i) begin
      wr_state_q <= WIdle;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= 2'b00;
      wdrain_q   <= 1'b0;
      wr_timer_q <= '0;
      rd_state_q <= RIdle;
      ar_full_q  <= 1'b0;
      ar_addr_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rdrain_q   <= 1'b0;
      rd_timer_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      wdrain_q   <= wdrain_d;
      wr_timer_q <= wr_timer_d;
      rd_state_q <= rd_state_d;
      ar_full_q  <= ar_full_d;
      ar_addr_q  <= ar_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rdrain_q   <= rdrain_d;
      rd_timer_q <= rd_timer_d;
      timeout_q  <= wr_timeout | rd_timeout;
    end
  end

endmodule

// File: tb/tb_axi4lite_axi4_bridge.sv
// Directed self-checking bench for axi4lite_axi4_bridge (TIMEOUT_CYCLES = 16).
module tb_axi4lite_axi4_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [31:0] awaddr;  logic awvalid;  logic awready;
  logic [31:0] wdata;   logic [3:0] wstrb; logic wvalid; logic wready;
  logic [1:0]  bresp;   logic bvalid;   logic bready;
  logic [31:0] araddr;  logic arvalid;  logic arready;
  logic [31:0] rdata;   logic [1:0] rresp; logic rvalid; logic rready;
  logic [0:0]  m_awid;  logic [31:0] m_awaddr; logic [7:0] m_awlen; logic [2:0] m_awsize;
  logic [1:0]  m_awburst; logic m_awlock; logic [3:0] m_awcache; logic [2:0] m_awprot;
  logic [3:0]  m_awqos; logic m_awvalid; logic m_awready;
  logic [31:0] m_wdata; logic [3:0] m_wstrb; logic m_wlast; logic m_wvalid; logic m_wready;
  logic [0:0]  m_bid;   logic [1:0] m_bresp; logic m_bvalid; logic m_bready;
  logic [0:0]  m_arid;  logic [31:0] m_araddr; logic [7:0] m_arlen; logic [2:0] m_arsize;
  logic [1:0]  m_arburst; logic m_arlock; logic [3:0] m_arcache; logic [2:0] m_arprot;
  logic [3:0]  m_arqos; logic m_arvalid; logic m_arready;
  logic [0:0]  m_rid;   logic [31:0] m_rdata; logic [1:0] m_rresp; logic m_rlast;
  logic        m_rvalid; logic m_rready;
  logic        timeout;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi4lite_axi4_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .TXN_ID(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .axi_rst_i(rst_n), .init_done_i(init_done),
    .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_araddr_i(araddr), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .m_axi_awid_o(m_awid), .m_axi_awaddr_o(m_awaddr), .m_axi_awlen_o(m_awlen),
    .m_axi_awsize_o(m_awsize), .m_axi_awburst_o(m_awburst), .m_axi_awlock_o(m_awlock),
    .m_axi_awcache_o(m_awcache), .m_axi_awprot_o(m_awprot), .m_axi_awqos_o(m_awqos),
    .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
    .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
    .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
    .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid),
    .m_axi_bready_o(m_bready),
    .m_axi_arid_o(m_arid), .m_axi_araddr_o(m_araddr), .m_axi_arlen_o(m_arlen),
    .m_axi_arsize_o(m_arsize), .m_axi_arburst_o(m_arburst), .m_axi_arlock_o(m_arlock),
    .m_axi_arcache_o(m_arcache), .m_axi_arprot_o(m_arprot), .m_axi_arqos_o(m_arqos),
    .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
    .m_axi_rid_i(m_rid), .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp),
    .m_axi_rlast_i(m_rlast), .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready),
    .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp_in, input logic bid_in,
                           input logic [1:0] exp_resp);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = 4'hF; wvalid = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wt_awvalid", 64'(m_awvalid), 64'd1);
    chk("wt_awaddr", 64'(m_awaddr), 64'(addr & 32'hFFFF_FFFC));
    chk("wt_wdata", 64'(m_wdata), 64'(data));
    step();
    chk("wt_bready", 64'(m_bready), 64'd1);
    m_bvalid = 1'b1; m_bresp = resp_in; m_bid = bid_in;
    step();
    m_bvalid = 1'b0; m_bid = 1'b0;
    chk("wt_bvalid", 64'(bvalid), 64'd1);
    chk("wt_bresp", 64'(bresp), 64'(exp_resp));
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("wt_bvalid_clr", 64'(bvalid), 64'd0);
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp_in, input logic rid_in, input logic last_in,
                          input logic [1:0] exp_resp);
    araddr = addr; arvalid = 1'b1; m_arready = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    chk("rt_arvalid", 64'(m_arvalid), 64'd1);
    chk("rt_araddr", 64'(m_araddr), 64'(addr & 32'hFFFF_FFFC));
    step();
    chk("rt_rready", 64'(m_rready), 64'd1);
    m_rvalid = 1'b1; m_rdata = data; m_rresp = resp_in; m_rid = rid_in; m_rlast = last_in;
    step();
    m_rvalid = 1'b0; m_rid = 1'b0; m_rlast = 1'b1;
    chk("rt_rvalid", 64'(rvalid), 64'd1);
    chk("rt_rresp", 64'(rresp), 64'(exp_resp));
    chk("rt_rdata", 64'(rdata), 64'(data));
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rt_rvalid_clr", 64'(rvalid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b1;
    m_rvalid = 1'b0;

    // Reset state
    #2;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_valids", 64'({bvalid, rvalid, m_awvalid, m_wvalid, m_arvalid}), 64'd0);
    chk("rst_readies", 64'({m_bready, m_rready}), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_awready", 64'(awready), 64'd1);

    // Write 0x1004 / DEADBEEF, instant slave, B one cycle after handshake
    awaddr = 32'h0000_1004; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    wvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    chk("t1_awready", 64'(awready), 64'd1);
    chk("t1_wready", 64'(wready), 64'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("t1_m_wvalid", 64'(m_wvalid), 64'd1);
    chk("t1_m_awaddr", 64'(m_awaddr), 64'h1004);
    chk("t1_len_size_burst", 64'({m_awlen, m_awsize, m_awburst}), 64'({8'd0, 3'd2, 2'b01}));
    chk("t1_lock_cache_prot_qos", 64'({m_awlock, m_awcache, m_awprot, m_awqos}),
        64'({1'b0, 4'b0011, 3'b000, 4'd0}));
    chk("t1_wlast", 64'(m_wlast), 64'd1);
    chk("t1_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    chk("t1_wstrb", 64'(m_wstrb), 64'hF);
    step();
    chk("t1_m_valids_low", 64'({m_awvalid, m_wvalid}), 64'd0);
    chk("t1_m_bready", 64'(m_bready), 64'd1);
    step();
    chk("t1_bvalid_early", 64'(bvalid), 64'd0);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    step();
    m_bvalid = 1'b0;
    chk("t1_bvalid", 64'(bvalid), 64'd1);
    chk("t1_bresp", 64'(bresp), 64'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("t1_bvalid_clr", 64'(bvalid), 64'd0);

    // W two cycles before AW; master awready held off for 5 cycles
    m_awready = 1'b0; m_wready = 1'b1;
    wdata = 32'h1122_3344; wstrb = 4'h3; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("t2_wready_full", 64'(wready), 64'd0);
    chk("t2_no_issue", 64'(m_awvalid), 64'd0);
    step();
    awaddr = 32'h0000_0040; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("t2_c1_valids", 64'({m_awvalid, m_wvalid}), 64'b11);
    chk("t2_wstrb", 64'(m_wstrb), 64'h3);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("t2_hold_valids", 64'({m_awvalid, m_wvalid}), 64'b10);
      if (c == 5) m_awready = 1'b1;
    end
    step();
    chk("t2_awvalid_low", 64'(m_awvalid), 64'd0);
    chk("t2_m_awaddr", 64'(m_awaddr), 64'h40);
    chk("t2_m_bready", 64'(m_bready), 64'd1);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    step();
    m_bvalid = 1'b0;
    chk("t2_bvalid", 64'(bvalid), 64'd1);
    chk("t2_bready_lresp", 64'(m_bready), 64'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("t2_bvalid_clr", 64'(bvalid), 64'd0);
    step();
    chk("t2_one_b", 64'(bvalid), 64'd0);

    // Init-done gating on the read address channel
    init_done = 1'b0; araddr = 32'h0000_2007; arvalid = 1'b1; m_arready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t3_arready_gated", 64'({arready, awready, wready}), 64'd0);
      step();
    end
    chk("t3_no_issue", 64'(m_arvalid), 64'd0);
    init_done = 1'b1;
    #1;
    chk("t3_arready_open", 64'(arready), 64'd1);
    step();
    arvalid = 1'b0;
    chk("t3_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("t3_araddr_aligned", 64'(m_araddr), 64'h2004);
    chk("t3_arlen_size", 64'({m_arlen, m_arsize, m_arburst}), 64'({8'd0, 3'd2, 2'b01}));
    step();
    chk("t3_m_rready", 64'(m_rready), 64'd1);
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b00;
    step();
    m_rvalid = 1'b0;
    chk("t3_rvalid", 64'(rvalid), 64'd1);
    chk("t3_rdata", 64'(rdata), 64'hCAFE_F00D);
    chk("t3_rresp", 64'(rresp), 64'd0);
    rready = 1'b1;
    step();
    rready = 1'b0;

    // Read timeout after 16 response cycles, then a late R is drained
    araddr = 32'h0000_3000; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    step();
    chk("t4_resp_wait", 64'(m_rready), 64'd1);
    for (int c = 1; c < 16; c++) begin
      step();
      chk("t4_waiting", 64'({rvalid, timeout}), 64'd0);
    end
    step();
    chk("t4_timeout_pulse", 64'(timeout), 64'd1);
    chk("t4_rvalid", 64'(rvalid), 64'd1);
    chk("t4_rresp_slverr", 64'(rresp), 64'd2);
    chk("t4_rdata_zero", 64'(rdata), 64'd0);
    chk("t4_drain_rready", 64'(m_rready), 64'd1);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("t4_timeout_one_cycle", 64'(timeout), 64'd0);
    araddr = 32'h0000_3008; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t4_held_by_drain", 64'({m_arvalid, m_rready}), 64'b01);
    end
    m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0; m_rresp = 2'b00;
    step();
    m_rvalid = 1'b0;
    chk("t4_late_absorbed", 64'({rvalid, m_arvalid}), 64'd0);
    step();
    chk("t4_next_issue", 64'(m_arvalid), 64'd1);
    chk("t4_next_addr", 64'(m_araddr), 64'h3008);
    step();
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rresp = 2'b00;
    step();
    m_rvalid = 1'b0;
    chk("t4_next_data", 64'(rdata), 64'h1234_5678);
    chk("t4_next_resp", 64'({rvalid, rresp}), 64'b100);
    rready = 1'b1;
    step();
    rready = 1'b0;

    // Response mapping and ID/RLAST checks
    read_txn(32'h0000_4000, 32'h55AA_55AA, 2'b01, 1'b0, 1'b1, 2'b00);
    read_txn(32'h0000_4004, 32'hA5A5_0001, 2'b00, 1'b1, 1'b1, 2'b10);
    read_txn(32'h0000_4008, 32'hA5A5_0002, 2'b00, 1'b0, 1'b0, 2'b10);
    read_txn(32'h0000_400C, 32'hA5A5_0003, 2'b11, 1'b0, 1'b1, 2'b11);
    write_txn(32'h0000_5000, 32'h0BAD_F00D, 2'b10, 1'b0, 2'b10);
    write_txn(32'h0000_5004, 32'h0000_0001, 2'b01, 1'b0, 2'b00);
    write_txn(32'h0000_5008, 32'h0000_0002, 2'b00, 1'b1, 2'b10);

    // Concurrent read and write, reset asserted while both are issuing
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    awaddr = 32'h0000_6000; awvalid = 1'b1; wdata = 32'h6666_6666; wvalid = 1'b1;
    araddr = 32'h0000_7000; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t6_all_issuing", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valids", 64'({m_awvalid, m_wvalid, m_arvalid, bvalid, rvalid}), 64'd0);
    chk("t6_async_readies", 64'({awready, wready, arready, m_bready, m_rready}), 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("t6_idle_after_rst", 64'({m_awvalid, m_arvalid, awready}), 64'b001);
    write_txn(32'h0000_8004, 32'hFEED_FACE, 2'b00, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4lite_axi4_bridge.md
Name: axi4lite_axi4_bridge

Overview:
- Converts an AXI4-Lite slave port into single-beat AXI4 master transactions for the DDR3 memory controller's AXI4 slave port.
- Width and ID are parametrised. The read and write channels are independent.
- Adds behaviour not present before: init-done gating, response timeout with late-response drain, and ID/RLAST checking.
- Sits between the system interconnect and the DDR3 controller. Everything runs on one clock domain.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width on both sides; legal values are 32, 64, 128.
- ID_WIDTH, 1, AXI4 ID width.
- TXN_ID, 0, constant ID driven on m_axi_awid and m_axi_arid.
- TIMEOUT_CYCLES, 1024, maximum number of cycles to wait for B/R after the request handshakes; 0 disables the timeout.

Ports:
- clk_i in 1: clock.
- axi_rst_i in 1: reset, asynchronous, active-low.
- init_done_i in 1: memory calibration complete.
- axi_awaddr_i/awvalid_i/awready_o, axi_wdata_i/wstrb_i/wvalid_i/wready_o, axi_bresp_o/bvalid_o/bready_i: AXI4-Lite write slave channels (ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8, 2).
- axi_araddr_i/arvalid_i/arready_o, axi_rdata_o/rresp_o/rvalid_o/rready_i: AXI4-Lite read slave channels.
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}_o out; m_axi_awready_i in.
- m_axi_w{data,strb,last,valid}_o out; m_axi_wready_i in.
- m_axi_b{id,resp,valid}_i in; m_axi_bready_o out.
- m_axi_ar* out and m_axi_arready_i in: mirror of the AW channel.
- m_axi_r{id,data,resp,last,valid}_i in; m_axi_rready_o out.
- timeout_o out 1: one-cycle pulse per timed-out transaction.

Behaviour:
- Reset:
  - All valid/ready outputs are 0, FSMs go to IDLE, data/addr/resp registers are 0.
  - timeout_o is 0 and the drain flags are cleared.
  - On reset mid-transaction, everything is abandoned immediately.
- Static fields:
  - len = 0, size = log2(DATA_WIDTH/8), burst = INCR (01).
  - lock = 0, cache = 0011, prot = 000, qos = 0, wlast = 1.
  - Outgoing addresses are forced aligned: the low log2(DATA_WIDTH/8) bits are zeroed.
- Gating: while init_done_i = 0, axi_awready_o, axi_wready_o and axi_arready_o are held at 0.
- Write FSM:
  - W_IDLE:
    - awready_o and wready_o are asserted independently; each handshake captures its channel into a register.
    - Once both are captured and wdrain = 0, go to W_ISSUE.
    - AW and W captured in the same cycle reach W_ISSUE on the next cycle.
  - W_ISSUE:
    - m_awvalid_o and m_wvalid_o assert together.
    - Each deasserts after its own handshake; valid is never withdrawn before its handshake.
    - When both handshakes are done, go to W_RESP.
  - W_RESP:
    - m_bready_o = 1 and the timer counts.
    - On bvalid: bresp is mapped (see below), then go to W_LRESP.
    - If the timer reaches TIMEOUT_CYCLES first: resp = SLVERR, set wdrain, pulse timeout_o, go to W_LRESP.
  - W_LRESP: axi_bvalid_o = 1 until bready_i, then go to W_IDLE.
  - Drain: while wdrain = 1, m_bready_o = 1 in every state. The first B beat clears wdrain and is discarded. No new write issues until wdrain clears.
- Read FSM, analogous:
  - States are R_IDLE, R_ISSUE, R_RESP, R_LRESP, with an rdrain flag.
  - rdata is registered on the R handshake.
  - On timeout, rdata = 0.
- Response mapping:
  - OKAY and EXOKAY map to OKAY; SLVERR and DECERR pass through.
  - bid/rid not equal to TXN_ID, or rlast = 0, forces SLVERR.
- Latency (zero-wait slave): Lite AW+W -> m_awvalid is 1 cycle. Master B -> lite bvalid is 1 cycle. Read timing is the same.
- Concurrency: one outstanding transaction per direction. Read and write run fully concurrently.
- Timer: a single counter per direction, cleared on entering *_RESP and saturating. Width is clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Write 0x0000_1004 / 0xDEADBEEF, wstrb 0xF, slave instant-ready with bresp 00 -> master awaddr 0x1004, len 0, size 2, wlast 1; lite bresp 00, 3 cycles after the handshakes.
- W given 2 cycles before AW; master awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle and awvalid holds 5 cycles; exactly one B.
- init_done_i = 0 while arvalid is asserted for 10 cycles -> arready 0 throughout; init_done_i rises -> accepted next cycle.
- Read with TIMEOUT_CYCLES = 16 and no rvalid -> after 16 cycles: timeout_o pulse, lite rresp 10, rdata 0. Late R at cycle 30 is absorbed. The next read waits until then and returns correct data.
- Read where the slave returns rresp 01 (EXOKAY), then a read with rid = 1 -> lite rresp 00, then 10.
- Simultaneous read and write, then assert axi_rst_i low mid-W_ISSUE -> all valids 0 asynchronously; after release, a new write completes normally.
